// File: rtl/instruction_decode.sv
// Decode stage: register file with write-back bypass, immediate/control decode,
// load-use hazard detection and the ID/EX pipeline register.
module instruction_decode #(
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_en,
    input  logic        i_flush,
    input  logic [31:0] i_if_inst,
    input  logic [31:0] i_if_pc,
    input  logic        i_wb_we,
    input  logic [4:0]  i_wb_rd,
    input  logic [31:0] i_wb_data,
    output logic [31:0] o_id_pc,
    output logic [31:0] o_id_rs1_data,
    output logic [31:0] o_id_rs2_data,
    output logic [31:0] o_id_imm,
    output logic [4:0]  o_id_rs1,
    output logic [4:0]  o_id_rs2,
    output logic [4:0]  o_id_rd,
    output logic [2:0]  o_id_funct3,
    output logic [3:0]  o_id_alu_op,
    output logic        o_id_alu_src,
    output logic        o_id_mem_rd,
    output logic        o_id_mem_wr,
    output logic        o_id_reg_wr,
    output logic        o_id_branch,
    output logic        o_id_jump,
    output logic        o_id_illegal,
    output logic        o_load_use_stall
);

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6F;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [3:0]  alu_op;
        logic        alu_src;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
        logic        branch;
        logic        jump;
        logic        illegal;
    } idex_t;

    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic b30,
                                               input logic is_op);
        logic [3:0] op;
        case (f3)
            3'd0:    op = (is_op && b30) ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = b30 ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [31:0] regs [32];
    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2, rd_f;
    logic [31:0] rs1_data, rs2_data;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        fwd1, fwd2, use_rs1, use_rs2;
    idex_t       dec, idex_q;

    assign opcode = i_if_inst[6:0];
    assign rs1    = i_if_inst[19:15];
    assign rs2    = i_if_inst[24:20];
    assign rd_f   = i_if_inst[11:7];

    // Write port is independent of clk_en so write-back never stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (i_wb_we && i_wb_rd != 5'd0) begin
            regs[i_wb_rd] <= i_wb_data;
        end
    end

    assign fwd1 = BYPASS_EN && i_wb_we && (i_wb_rd != 5'd0) && (i_wb_rd == rs1);
    assign fwd2 = BYPASS_EN && i_wb_we && (i_wb_rd != 5'd0) && (i_wb_rd == rs2);
    assign rs1_data = fwd1 ? i_wb_data : ((rs1 == 5'd0) ? 32'd0 : regs[rs1]);
    assign rs2_data = fwd2 ? i_wb_data : ((rs2 == 5'd0) ? 32'd0 : regs[rs2]);

    assign imm_i = {{20{i_if_inst[31]}}, i_if_inst[31:20]};
    assign imm_s = {{20{i_if_inst[31]}}, i_if_inst[31:25], i_if_inst[11:7]};
    assign imm_b = {{19{i_if_inst[31]}}, i_if_inst[31], i_if_inst[7], i_if_inst[30:25],
                    i_if_inst[11:8], 1'b0};
    assign imm_u = {i_if_inst[31:12], 12'b0};
    assign imm_j = {{11{i_if_inst[31]}}, i_if_inst[31], i_if_inst[19:12], i_if_inst[20],
                    i_if_inst[30:21], 1'b0};

    always_comb begin
        dec          = '0;
        use_rs1      = 1'b0;
        use_rs2      = 1'b0;
        dec.pc       = i_if_pc;
        dec.rs1_data = rs1_data;
        dec.rs2_data = rs2_data;
        dec.rs1      = rs1;
        dec.rs2      = rs2;
        dec.funct3   = i_if_inst[14:12];
        case (opcode)
            OPC_OP: begin
                dec.alu_op = alu_from_f3(i_if_inst[14:12], i_if_inst[30], 1'b1);
                dec.rd     = rd_f;
                dec.reg_wr = (rd_f != 5'd0);
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
            end
            OPC_OPIMM: begin
                dec.alu_op  = alu_from_f3(i_if_inst[14:12], i_if_inst[30], 1'b0);
                dec.alu_src = 1'b1;
                dec.imm     = imm_i;
                dec.rd      = rd_f;
                dec.reg_wr  = (rd_f != 5'd0);
                use_rs1     = 1'b1;
            end
            OPC_LOAD: begin
                dec.alu_src = 1'b1;
                dec.mem_rd  = 1'b1;
                dec.imm     = imm_i;
                dec.rd      = rd_f;
                dec.reg_wr  = (rd_f != 5'd0);
                use_rs1     = 1'b1;
            end
            OPC_STORE: begin
                dec.alu_src = 1'b1;
                dec.mem_wr  = 1'b1;
                dec.imm     = imm_s;
                use_rs1     = 1'b1;
                use_rs2     = 1'b1;
            end
            OPC_BRANCH: begin
                dec.alu_op = ALU_SUB;
                dec.branch = 1'b1;
                dec.imm    = imm_b;
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
            end
            OPC_LUI: begin
                dec.alu_op  = ALU_PASSB;
                dec.alu_src = 1'b1;
                dec.imm     = imm_u;
                dec.rd      = rd_f;
                dec.reg_wr  = (rd_f != 5'd0);
            end
            OPC_AUIPC: begin
                dec.alu_src = 1'b1;
                dec.imm     = imm_u;
                dec.rd      = rd_f;
                dec.reg_wr  = (rd_f != 5'd0);
            end
            OPC_JAL: begin
                dec.jump   = 1'b1;
                dec.imm    = imm_j;
                dec.rd     = rd_f;
                dec.reg_wr = (rd_f != 5'd0);
            end
            OPC_JALR: begin
                dec.alu_src = 1'b1;
                dec.jump    = 1'b1;
                dec.imm     = imm_i;
                dec.rd      = rd_f;
                dec.reg_wr  = (rd_f != 5'd0);
                use_rs1     = 1'b1;
            end
            // An all-zero word is an IF bubble and must not be flagged.
            default: dec.illegal = (i_if_inst != 32'd0);
        endcase
    end

    assign o_load_use_stall = idex_q.mem_rd && (idex_q.rd != 5'd0) &&
                              ((use_rs1 && idex_q.rd == rs1) || (use_rs2 && idex_q.rd == rs2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q <= '0;
        end else if (i_flush || (clk_en && o_load_use_stall)) begin
            idex_q <= '0;
        end else if (clk_en) begin
            idex_q <= dec;
        end
    end

    assign o_id_pc       = idex_q.pc;
    assign o_id_rs1_data = idex_q.rs1_data;
    assign o_id_rs2_data = idex_q.rs2_data;
    assign o_id_imm      = idex_q.imm;
    assign o_id_rs1      = idex_q.rs1;
    assign o_id_rs2      = idex_q.rs2;
    assign o_id_rd       = idex_q.rd;
    assign o_id_funct3   = idex_q.funct3;
    assign o_id_alu_op   = idex_q.alu_op;
    assign o_id_alu_src  = idex_q.alu_src;
    assign o_id_mem_rd   = idex_q.mem_rd;
    assign o_id_mem_wr   = idex_q.mem_wr;
    assign o_id_reg_wr   = idex_q.reg_wr;
    assign o_id_branch   = idex_q.branch;
    assign o_id_jump     = idex_q.jump;
    assign o_id_illegal  = idex_q.illegal;

endmodule

// File: doc/instruction_decode.md
INSTRUCTION_DECODE -- requirements
Module: instruction_decode

Interface
REQ-001 Parameter BYPASS_EN, default 1: when 1, a same-cycle write-back value is forwarded onto a read of the same register.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 clk_en  input  1  pipeline advance enable; 0 holds the ID/EX register.
REQ-005 i_flush  input  1  branch/jump taken; the instruction now in decode is squashed.
REQ-006 i_if_inst, i_if_pc  input  32 each  instruction and PC from the IF/ID register.
REQ-007 i_wb_we  input  1; i_wb_rd  input  5; i_wb_data  input  32  register-file write port.
REQ-008 o_id_pc, o_id_rs1_data, o_id_rs2_data, o_id_imm  output  32 each  registered ID/EX data.
REQ-009 o_id_rs1, o_id_rs2, o_id_rd  output  5 each; o_id_funct3  output  3  registered fields.
REQ-010 o_id_alu_op  output  4; o_id_alu_src, o_id_mem_rd, o_id_mem_wr, o_id_reg_wr, o_id_branch, o_id_jump, o_id_illegal  output  1 each  registered control.
REQ-011 o_load_use_stall  output  1  combinational hazard request, used to deassert clk_en on IF.

Function
REQ-012 Register file: 32x32 registers; x0 reads 0; writes to x0 are ignored.
REQ-013 Write: on each rising edge with i_wb_we=1 and i_wb_rd!=0, the register is written; clk_en does not gate the write.
REQ-014 Read: asynchronous on rs1=inst[19:15] and rs2=inst[24:20].
REQ-015 Forwarding (BYPASS_EN=1): if i_wb_we=1, i_wb_rd!=0 and i_wb_rd equals rs1 or rs2, the read returns i_wb_data.
REQ-016 Immediate decode by opcode:
  - I: sign-extended inst[31:20].
  - S: {inst[31:25], inst[11:7]}, sign-extended.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}, sign-extended.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}, sign-extended.
  - R-type: 0.
REQ-017 alu_op encoding: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASSB=10.
REQ-018 alu_op selection:
  - OP/OP-IMM: from funct3, with inst[30] selecting SUB (OP only) or SRA.
  - LUI: PASSB.
  - Loads, stores, AUIPC, JAL, JALR: ADD.
  - Branches: SUB.
REQ-019 Control per opcode:
  - alu_src=1 for OP-IMM, loads, stores, LUI, AUIPC, JALR.
  - mem_rd=1 for loads; mem_wr=1 for stores.
  - reg_wr=1 for OP, OP-IMM, loads, LUI, AUIPC, JAL, JALR, and only when rd!=0.
  - branch=1 for BRANCH; jump=1 for JAL and JALR.
REQ-020 Unsupported opcode: all control outputs 0 and o_id_illegal=1; the all-zero word 0x00000000 (IF bubble) decodes as a NOP with o_id_illegal=0.
REQ-021 Load-use hazard: o_load_use_stall=1 when all of the following hold in the same cycle:
  - o_id_mem_rd=1 and o_id_rd!=0;
  - o_id_rd equals rs1 (for formats using rs1) or rs2 (for R, S, B formats).
REQ-022 ID/EX update priority on each rising edge:
  - i_flush: load a bubble, even when clk_en=0.
  - else clk_en=1 with o_load_use_stall=1: load a bubble.
  - else clk_en=1: load the decoded values.
  - else (clk_en=0): hold.
REQ-023 Bubble: all control outputs and o_id_illegal are 0, and o_id_rd=0; data fields are don't-care but driven to 0.
REQ-024 Latency: decode results appear on the outputs one cycle after i_if_inst is presented with clk_en=1.

Reset
REQ-025 While rst_n=0: all ID/EX outputs are 0 and all 32 registers are 0, asynchronously.
REQ-026 Reset asserted mid-operation discards any in-flight write.
REQ-027 Leaving reset: the first clocked edge with clk_en=1 decodes the current i_if_inst.

Verification
REQ-028 Reset, then i_if_inst=0x00500093 (addi x1,x0,5) with clk_en=1 -> next cycle:
  - o_id_imm=5, o_id_rd=1, o_id_alu_op=0;
  - o_id_alu_src=1, o_id_reg_wr=1.
REQ-029 Write x2=0xDEADBEEF via WB; the same cycle decode add x3,x2,x2 -> o_id_rs1_data=o_id_rs2_data=0xDEADBEEF (bypass).
REQ-030 Load-use stall:
  - lw x5,0(x1) followed by add x6,x5,x0 -> o_load_use_stall=1 for one cycle.
  - The next ID/EX entry is a bubble (reg_wr=0).
  - The add decodes after the stall clears.
REQ-031 i_flush=1 with clk_en=0 while decoding a store -> next cycle o_id_mem_wr=0 and o_id_rd=0.
REQ-032 Decode beq with offset -8 (0xFE000CE3) -> o_id_imm=0xFFFFFFF8, o_id_branch=1, o_id_alu_op=1.
REQ-033 Decode opcode 0x7F -> o_id_illegal=1 with all control 0; write x0=7 then read x0 -> 0.
